// File: rtl/sent_rx_frame.sv
// sent_rx_frame: SENT fast-channel receiver (sync lock, nibble decode, CRC4 check).
// Define SENT_PAUSE_EN to accept a pause pulse between frames without an error.
module sent_rx_frame #(
    parameter int TICK_DIV     = 150,
    parameter int DATA_NIBBLES = 6
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic                      sent_i,
    output logic                      frame_valid_o,
    output logic [3:0]                status_o,
    output logic [4*DATA_NIBBLES-1:0] data_o,
    output logic                      crc_err_o,
    output logic                      frame_err_o,
    output logic                      sync_lock_o
);
    localparam int DW = 4 * DATA_NIBBLES;
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_HALF = PW'(TICK_DIV / 2);

    typedef enum logic [2:0] {HUNT, SYNC, STATUS, DATA, CRC, POST} state_t;

    state_t          state_q, state_d;
    logic [2:0]      sync_q;
    logic [PW-1:0]   pre_q;
    logic [9:0]      ticks_q;
    logic [3:0]      crc_q, crc_d;
    logic [3:0]      idx_q, idx_d;
    logic [DW-1:0]   shadow_q, shadow_d;
    logic [3:0]      st_sh_q, st_sh_d;
    logic [DW-1:0]   data_q, data_d;
    logic [3:0]      status_q, status_d;
    logic            fv_q, fv_d, cerr_q, cerr_d, ferr_q, ferr_d, lock_q, lock_d;
    logic            fall, timeout, is_sync, nib_ok, pause_ok, bad;
    logic [10:0]     t_w;
    logic [3:0]      nib;

    function automatic logic [3:0] crc4(input logic [3:0] c, input logic [3:0] d);
        logic [3:0] x;
        x = c ^ d;
        return {x[0] ^ x[2], x[0] ^ x[1] ^ x[2], x[1] ^ x[2], x[0] ^ x[1] ^ x[3]};
    endfunction

    // sync_q[2] is the previous synchronized sample, sync_q[1] the current one
    assign fall     = sync_q[2] & ~sync_q[1];
    assign t_w      = {1'b0, ticks_q} + 11'(pre_q >= PRE_HALF);
    assign is_sync  = (t_w >= 11'd55) && (t_w <= 11'd57);
    assign nib_ok   = (t_w >= 11'd12) && (t_w <= 11'd27);
    assign pause_ok = (t_w >= 11'd12) && (t_w <= 11'd768);
    assign nib      = 4'(t_w - 11'd12);
    assign timeout  = (ticks_q == 10'd1023) && (state_q != HUNT);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync_q  <= '0;
            pre_q   <= '0;
            ticks_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], sent_i};
            if (fall) begin
                pre_q   <= '0;
                ticks_q <= '0;
            end else if (pre_q == PRE_MAX) begin
                pre_q   <= '0;
                ticks_q <= (ticks_q == 10'd1023) ? ticks_q : ticks_q + 10'd1;
            end else begin
                pre_q <= pre_q + PW'(1);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        crc_d    = crc_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        st_sh_d  = st_sh_q;
        data_d   = data_q;
        status_d = status_q;
        cerr_d   = cerr_q;
        lock_d   = lock_q;
        fv_d     = 1'b0;
        ferr_d   = 1'b0;
        bad      = 1'b0;
        if (timeout) begin
            state_d = HUNT;
            lock_d  = 1'b0;
            ferr_d  = (state_q == STATUS) || (state_q == DATA) || (state_q == CRC);
        end else if (fall) begin
            case (state_q)
                HUNT: state_d = SYNC;
                SYNC, POST: begin
                    if (is_sync) begin
                        state_d = STATUS;
                        lock_d  = 1'b1;
                        crc_d   = 4'b0101;
                        idx_d   = '0;
                    end else if (state_q == POST) begin
`ifdef SENT_PAUSE_EN
                        if (pause_ok) state_d = SYNC;
                        else bad = 1'b1;
`else
                        bad = 1'b1;
`endif
                    end
                end
                STATUS: begin
                    if (nib_ok) begin
                        st_sh_d = nib;
                        state_d = DATA;
                    end else bad = 1'b1;
                end
                DATA: begin
                    if (nib_ok) begin
                        shadow_d = (shadow_q << 4) | DW'(nib);
                        crc_d    = crc4(crc_q, nib);
                        idx_d    = idx_q + 4'd1;
                        state_d  = (idx_q == 4'(DATA_NIBBLES - 1)) ? CRC : DATA;
                    end else bad = 1'b1;
                end
                CRC: begin
                    if (nib_ok) begin
                        fv_d     = 1'b1;
                        data_d   = shadow_q;
                        status_d = st_sh_q;
                        cerr_d   = (nib != crc_q);
                        state_d  = POST;
                    end else bad = 1'b1;
                end
                default: state_d = HUNT;
            endcase
            if (bad) begin
                ferr_d  = 1'b1;
                lock_d  = 1'b0;
                state_d = SYNC;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= HUNT;
            crc_q    <= 4'b0101;
            idx_q    <= '0;
            shadow_q <= '0;
            st_sh_q  <= '0;
            data_q   <= '0;
            status_q <= '0;
            cerr_q   <= 1'b0;
            lock_q   <= 1'b0;
            fv_q     <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            crc_q    <= crc_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            st_sh_q  <= st_sh_d;
            data_q   <= data_d;
            status_q <= status_d;
            cerr_q   <= cerr_d;
            lock_q   <= lock_d;
            fv_q     <= fv_d;
            ferr_q   <= ferr_d;
        end
    end

    assign frame_valid_o = fv_q;
    assign status_o      = status_q;
    assign data_o        = data_q;
    assign crc_err_o     = cerr_q;
    assign frame_err_o   = ferr_q;
    assign sync_lock_o   = lock_q;
endmodule

// File: tb/tb_sent_rx_frame.sv
// tb_sent_rx_frame: directed bench for sent_rx_frame with TICK_DIV=4.
// Build with SENT_PAUSE_EN defined to exercise the pause-pulse variant.
module tb_sent_rx_frame;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sent = 1'b1;
    logic        fv, cerr, ferr, lock;
    logic [3:0]  status;
    logic [23:0] data;
    int          checks = 0;
    int          errors = 0;
    int          fv_cnt = 0;
    int          fe_cnt = 0;
    logic [23:0] log_d [8];
    logic [3:0]  log_s [8];
    logic        log_e [8];

    sent_rx_frame #(.TICK_DIV(4), .DATA_NIBBLES(6)) dut (
        .clk_i(clk), .reset_ni(reset_n), .sent_i(sent),
        .frame_valid_o(fv), .status_o(status), .data_o(data),
        .crc_err_o(cerr), .frame_err_o(ferr), .sync_lock_o(lock)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fv) begin
            log_d[fv_cnt[2:0]] <= data;
            log_s[fv_cnt[2:0]] <= status;
            log_e[fv_cnt[2:0]] <= cerr;
            fv_cnt <= fv_cnt + 1;
        end
        if (ferr) fe_cnt <= fe_cnt + 1;
    end

    task automatic pulse(input int t);
        sent = 1'b0;
        repeat (20) @(negedge clk);
        sent = 1'b1;
        repeat (4 * t - 20) @(negedge clk);
    endtask

    task automatic close_frame();
        sent = 1'b0;
        repeat (20) @(negedge clk);
        sent = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic frame(input int sy, input int st, input logic [23:0] dv, input int c);
        pulse(sy);
        pulse(12 + st);
        for (int i = 0; i < 6; i++) pulse(12 + int'(dv[23 - 4 * i -: 4]));
        pulse(12 + c);
    endtask

    task automatic do_reset();
        sent = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        sent = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({fv, status, data, cerr, ferr, lock} !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {fv, status, data, cerr, ferr, lock});
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({fv, ferr, lock} !== 3'b000) begin
            errors++;
            $display("FAIL post_reset_flags: got %b expected 000", {fv, ferr, lock});
        end
    endtask

    task automatic test_valid();
        int f0, e0;
        do_reset();
        f0 = fv_cnt; e0 = fe_cnt;
        frame(56, 0, 24'h000000, 15);
        close_frame();
        checks++;
        if (fv_cnt - f0 !== 1) begin errors++; $display("FAIL valid_count: got %0d expected 1", fv_cnt - f0); end
        checks++;
        if (log_d[f0[2:0]] !== 24'h000000 || log_s[f0[2:0]] !== 4'h0) begin
            errors++; $display("FAIL valid_data: got %h/%h expected 000000/0", log_d[f0[2:0]], log_s[f0[2:0]]);
        end
        checks++;
        if (log_e[f0[2:0]] !== 1'b0) begin errors++; $display("FAIL valid_crc_err: got %b expected 0", log_e[f0[2:0]]); end
        checks++;
        if (lock !== 1'b1 || fe_cnt - e0 !== 0) begin
            errors++; $display("FAIL valid_lock: got lock %b ferr %0d expected 1/0", lock, fe_cnt - e0);
        end
    endtask

    task automatic test_crc_err();
        int f0;
        do_reset();
        f0 = fv_cnt;
        frame(56, 0, 24'h000000, 0);
        close_frame();
        checks++;
        if (fv_cnt - f0 !== 1 || log_e[f0[2:0]] !== 1'b1) begin
            errors++; $display("FAIL crc_err: got count %0d err %b expected 1/1", fv_cnt - f0, log_e[f0[2:0]]);
        end
        checks++;
        if (data !== 24'h000000) begin errors++; $display("FAIL crc_err_data: got %h expected 000000", data); end
    endtask

    task automatic test_back_to_back();
        int f0;
        do_reset();
        f0 = fv_cnt;
        frame(55, 10, 24'h123456, 8);
        frame(57, 0, 24'h000000, 15);
        close_frame();
        checks++;
        if (fv_cnt - f0 !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", fv_cnt - f0); end
        checks++;
        if (log_d[f0[2:0]] !== 24'h123456 || log_s[f0[2:0]] !== 4'hA || log_e[f0[2:0]] !== 1'b0) begin
            errors++; $display("FAIL b2b_first: got %h/%h/%b expected 123456/a/0", log_d[f0[2:0]], log_s[f0[2:0]], log_e[f0[2:0]]);
        end
        checks++;
        if (data !== 24'h000000 || status !== 4'h0 || cerr !== 1'b0) begin
            errors++; $display("FAIL b2b_second: got %h/%h/%b expected 000000/0/0", data, status, cerr);
        end
    endtask

    task automatic test_sync_hunt();
        int f0, e0;
        do_reset();
        f0 = fv_cnt; e0 = fe_cnt;
        pulse(40);
        frame(56, 0, 24'h000000, 15);
        close_frame();
        checks++;
        if (fe_cnt - e0 !== 0) begin errors++; $display("FAIL hunt_ferr: got %0d expected 0", fe_cnt - e0); end
        checks++;
        if (fv_cnt - f0 !== 1 || lock !== 1'b1) begin
            errors++; $display("FAIL hunt_decode: got count %0d lock %b expected 1/1", fv_cnt - f0, lock);
        end
    endtask

    task automatic test_bad_status();
        int f0, e0;
        do_reset();
        f0 = fv_cnt; e0 = fe_cnt;
        pulse(56);
        sent = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (lock !== 1'b1) begin errors++; $display("FAIL bad_status_lock_before: got %b expected 1", lock); end
        sent = 1'b1;
        repeat (4 * 30 - 20) @(negedge clk);
        close_frame();
        checks++;
        if (fe_cnt - e0 !== 1 || lock !== 1'b0 || fv_cnt - f0 !== 0) begin
            errors++; $display("FAIL bad_status: got ferr %0d lock %b fv %0d expected 1/0/0", fe_cnt - e0, lock, fv_cnt - f0);
        end
    endtask

    task automatic test_timeout();
        int f0, e0;
        do_reset();
        f0 = fv_cnt; e0 = fe_cnt;
        pulse(56); pulse(12); pulse(12); pulse(12);
        close_frame();
        checks++;
        if (fe_cnt - e0 !== 0 || lock !== 1'b1) begin
            errors++; $display("FAIL timeout_before: got ferr %0d lock %b expected 0/1", fe_cnt - e0, lock);
        end
        repeat (4100) @(negedge clk);
        checks++;
        if (fe_cnt - e0 !== 1 || lock !== 1'b0 || fv_cnt - f0 !== 0) begin
            errors++; $display("FAIL timeout: got ferr %0d lock %b fv %0d expected 1/0/0", fe_cnt - e0, lock, fv_cnt - f0);
        end
    endtask

    task automatic test_reset_mid();
        int f0, e0;
        do_reset();
        frame(55, 10, 24'h123456, 8);
        close_frame();
        checks++;
        if (data !== 24'h123456 || status !== 4'hA) begin
            errors++; $display("FAIL mid_pre_data: got %h/%h expected 123456/a", data, status);
        end
        pulse(56); pulse(12);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({fv, status, data, cerr, ferr, lock} !== 32'h0) begin
            errors++; $display("FAIL mid_reset_outputs: got %h expected 0", {fv, status, data, cerr, ferr, lock});
        end
        f0 = fv_cnt; e0 = fe_cnt;
        reset_n = 1'b1;
        repeat (200) @(negedge clk);
        checks++;
        if (fv_cnt - f0 !== 0 || fe_cnt - e0 !== 0 || lock !== 1'b0) begin
            errors++; $display("FAIL mid_after: got fv %0d ferr %0d lock %b expected 0/0/0", fv_cnt - f0, fe_cnt - e0, lock);
        end
    endtask

    task automatic test_pause();
        int f0, e0, exp_fe;
`ifdef SENT_PAUSE_EN
        exp_fe = 0;
`else
        exp_fe = 1;
`endif
        do_reset();
        f0 = fv_cnt; e0 = fe_cnt;
        frame(56, 0, 24'h000000, 15);
        pulse(100);
        frame(56, 10, 24'h123456, 8);
        close_frame();
        checks++;
        if (fv_cnt - f0 !== 2) begin errors++; $display("FAIL pause_count: got %0d expected 2", fv_cnt - f0); end
        checks++;
        if (fe_cnt - e0 !== exp_fe) begin errors++; $display("FAIL pause_ferr: got %0d expected %0d", fe_cnt - e0, exp_fe); end
        checks++;
        if (data !== 24'h123456 || lock !== 1'b1 || cerr !== 1'b0) begin
            errors++; $display("FAIL pause_second: got %h lock %b err %b expected 123456/1/0", data, lock, cerr);
        end
    endtask

    initial begin
        test_reset();
        test_valid();
        test_crc_err();
        test_back_to_back();
        test_sync_hunt();
        test_bad_status();
        test_timeout();
        test_reset_mid();
        test_pause();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
